// File: rtl/teclado_digitos_pkg.sv
// Shared types for the keypad digit collector: digit buffer, key codes, FSM states.
`timescale 1ns/1ps
package teclado_digitos_pkg;

  localparam int N_DIGITS = 20;

  typedef struct packed {
    logic [N_DIGITS-1:0][3:0] digits;
  } senhaPac_t;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam senhaPac_t SENHA_EMPTY = '1;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE_PRESS,
    EMIT,
    WAIT_RELEASE,
    DEBOUNCE_RELEASE
  } state_t;

  // Letter keys (column 3 of rows 0-2, and r3c3) map to KEY_NONE and are dropped.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_NONE;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/teclado_digitos_debounce.sv
// Stable-pattern counter: latches a reference column pattern on start, then
// reports done after DEBOUNCE_CYCLES matching cycles or changed on any mismatch.
`timescale 1ns/1ps
module teclado_debounce #(
  parameter int DEBOUNCE_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  input  logic [3:0] pattern,
  output logic       done,
  output logic       changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    ref_q, ref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match;

  assign match   = (pattern == ref_q);
  assign done    = run && !start && match && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign changed = run && !start && !match;

  always_comb begin
    ref_d = ref_q;
    cnt_d = cnt_q;
    if (start) begin
      ref_d = pattern;
      cnt_d = '0;
    end else if (run) begin
      cnt_d = match ? CW'(cnt_q + 1'b1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q <= 4'hF;
      cnt_q <= '0;
    end else begin
      ref_q <= ref_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/teclado_digitos.sv
// 4x4 keypad scanner collecting debounced digits into a 20-digit shift buffer.
// Optional inactivity clear of the buffer: define TIMEOUT_CLEAR_EN.
`timescale 1ns/1ps
module teclado_digitos
  import teclado_digitos_pkg::*;
#(
  parameter int SCAN_CYCLES     = 100,
  parameter int DEBOUNCE_CYCLES = 50,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_matrix,
  output logic [3:0] lin_matrix,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid
);

  localparam int SW = $clog2(SCAN_CYCLES);

  if (SCAN_CYCLES < 3) begin : g_scan_range
    $error("SCAN_CYCLES must be at least 3");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_deb_range
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    key_col_q, key_col_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]    lin_q, lin_d;
  senhaPac_t     buf_q, buf_d;
  logic          valid_q, valid_d;
  logic          clr_next_q, clr_next_d;
  logic [3:0]    col_s1_q, col_s2_q;
  logic          deb_start, deb_run, deb_done, deb_changed;
  logic [3:0]    emit_code;
  logic          one_low;

`ifdef TIMEOUT_CLEAR_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  function automatic logic [1:0] low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign emit_code = key_code(row_q, key_col_q);
  assign one_low   = ($countones(~col_s2_q) == 1);

  teclado_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .start   (deb_start),
    .run     (deb_run),
    .pattern (col_s2_q),
    .done    (deb_done),
    .changed (deb_changed)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    key_col_d  = key_col_q;
    scan_cnt_d = scan_cnt_q;
    lin_d      = lin_q;
    buf_d      = buf_q;
    valid_d    = 1'b0;
    clr_next_d = 1'b0;
    deb_start  = 1'b0;
    deb_run    = 1'b0;
`ifdef TIMEOUT_CLEAR_EN
    to_cnt_d   = to_cnt_q;
`endif
    if (!enable) begin
      state_d    = SCAN;
      row_d      = 2'd0;
      scan_cnt_d = '0;
      lin_d      = 4'hF;
      buf_d      = SENHA_EMPTY;
`ifdef TIMEOUT_CLEAR_EN
      to_cnt_d   = '0;
`endif
    end else begin
      if (clr_next_q) buf_d = SENHA_EMPTY;
      case (state_q)
        SCAN: begin
          if (lin_q == 4'hF) begin
            lin_d      = row_drive(row_q);
            scan_cnt_d = '0;
          // The column synchroniser lags the row drive by two cycles.
          end else if (scan_cnt_q >= SW'(2) && one_low) begin
            state_d    = DEBOUNCE_PRESS;
            key_col_d  = low_col(col_s2_q);
            scan_cnt_d = '0;
            deb_start  = 1'b1;
          end else if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt_d = '0;
            row_d      = row_q + 2'd1;
            lin_d      = row_drive(row_q + 2'd1);
          end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
          end
        end
        DEBOUNCE_PRESS: begin
          deb_run = 1'b1;
          if (deb_changed)   state_d = SCAN;
          else if (deb_done) state_d = EMIT;
        end
        EMIT: begin
          if (emit_code != KEY_NONE) begin
            buf_d.digits = {buf_q.digits[N_DIGITS-2:0], emit_code};
            valid_d      = 1'b1;
            clr_next_d   = (emit_code == KEY_STAR) || (emit_code == KEY_HASH);
          end
          state_d = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (col_s2_q == 4'hF) begin
            state_d   = DEBOUNCE_RELEASE;
            deb_start = 1'b1;
          end
        end
        DEBOUNCE_RELEASE: begin
          deb_run = 1'b1;
          if (deb_changed)   state_d = WAIT_RELEASE;
          else if (deb_done) state_d = SCAN;
        end
        default: state_d = SCAN;
      endcase
`ifdef TIMEOUT_CLEAR_EN
      if (state_q == EMIT || buf_q == SENHA_EMPTY) begin
        to_cnt_d = '0;
      end else if (state_q == SCAN) begin
        if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_d = '0;
          buf_d    = SENHA_EMPTY;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      key_col_q  <= 2'd0;
      scan_cnt_q <= '0;
      lin_q      <= 4'hF;
      buf_q      <= SENHA_EMPTY;
      valid_q    <= 1'b0;
      clr_next_q <= 1'b0;
      col_s1_q   <= 4'hF;
      col_s2_q   <= 4'hF;
`ifdef TIMEOUT_CLEAR_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      key_col_q  <= key_col_d;
      scan_cnt_q <= scan_cnt_d;
      lin_q      <= lin_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      clr_next_q <= clr_next_d;
      col_s1_q   <= col_matrix;
      col_s2_q   <= col_s1_q;
`ifdef TIMEOUT_CLEAR_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign lin_matrix    = lin_q;
  assign digitos_value = buf_q;
  assign digitos_valid = valid_q;

endmodule

// File: tb/tb_teclado_digitos.sv
// Directed bench for teclado_digitos with a keypad model and an expected-value queue.
`timescale 1ns/1ps
module tb_teclado_digitos;
  import teclado_digitos_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] col_matrix;
  logic [3:0] lin_matrix;
  senhaPac_t  digitos_value;
  logic       digitos_valid;

  logic [15:0] keys_down;
  senhaPac_t   model;
  senhaPac_t   exp_q[$];
  int          checks     = 0;
  int          failures   = 0;
  int          pulse_cnt  = 0;
  int          exp_pulses = 0;

  always #5 clk = ~clk;

  teclado_digitos dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .col_matrix    (col_matrix),
    .lin_matrix    (lin_matrix),
    .digitos_value (digitos_value),
    .digitos_valid (digitos_valid)
  );

  // Passive keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_matrix = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !lin_matrix[r]) col_matrix[c] = 1'b0;
  end

  always @(negedge clk) if (digitos_valid) pulse_cnt++;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (digitos_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] code, input string tag);
    bit        got;
    senhaPac_t sb;
    model.digits = {model.digits[18:0], code};
    exp_q.push_back(model);
    exp_pulses++;
    keys_down[r*4+c] = 1'b1;
    wait_pulse(got);
    check({tag, "_pulse"}, got, 1'b1);
    sb = exp_q.pop_front();
    if (got) check({tag, "_value"}, digitos_value, sb);
    if (code == KEY_STAR || code == KEY_HASH) begin
      @(negedge clk);
      check({tag, "_cleared"}, digitos_value, SENHA_EMPTY);
      check({tag, "_valid_low"}, digitos_valid, 1'b0);
      model = SENHA_EMPTY;
    end
    repeat (200) @(negedge clk);
    keys_down = '0;
    repeat (200) @(negedge clk);
  endtask

  task automatic press_digit(input int d);
    int r, c;
    if (d == 0) begin
      r = 3; c = 1;
    end else begin
      r = (d - 1) / 3; c = (d - 1) % 3;
    end
    press_key(r, c, 4'(d), "seq");
  endtask

  initial begin
    bit        got;
    senhaPac_t sb;
    int        p0;
    model     = SENHA_EMPTY;
    keys_down = '0;
    enable    = 1'b0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lin", lin_matrix, 4'hF);
    check("rst_value", digitos_value, SENHA_EMPTY);
    check("rst_valid", digitos_valid, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    check("rst_hold_lin", lin_matrix, 4'hF);
    rst = 1'b1;

    // Row rotation after reset release
    @(negedge clk);
    check("row0_first", lin_matrix, 4'b1110);
    repeat (99) @(negedge clk);
    check("row0_last", lin_matrix, 4'b1110);
    @(negedge clk);
    check("row1", lin_matrix, 4'b1101);
    repeat (100) @(negedge clk);
    check("row2", lin_matrix, 4'b1011);
    repeat (100) @(negedge clk);
    check("row3", lin_matrix, 4'b0111);
    repeat (100) @(negedge clk);
    check("row_wrap", lin_matrix, 4'b1110);
    check("idle_value", digitos_value, SENHA_EMPTY);

    // 1 2 3 4 * then buffer clear
    press_key(0, 0, 4'h1, "key1");
    press_key(0, 1, 4'h2, "key2");
    press_key(0, 2, 4'h3, "key3");
    press_key(1, 0, 4'h4, "key4");
    press_key(3, 0, KEY_STAR, "star");
    check("pulses_after_star", pulse_cnt, exp_pulses);

    // '5' with bouncy contacts and a long hold
    for (int i = 0; i < 20; i++) begin
      keys_down[5] = i[1];
      @(negedge clk);
    end
    keys_down[5] = 1'b1;
    model.digits = {model.digits[18:0], 4'h5};
    exp_q.push_back(model);
    exp_pulses++;
    wait_pulse(got);
    check("key5_pulse", got, 1'b1);
    sb = exp_q.pop_front();
    check("key5_value", digitos_value, sb);
    check("key5_digit0", digitos_value.digits[0], 4'h5);
    repeat (10000) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      keys_down[5] = ~i[1];
      @(negedge clk);
    end
    keys_down = '0;
    repeat (300) @(negedge clk);
    check("key5_single_pulse", pulse_cnt, exp_pulses);

    // Letter key and two-key chord are both ignored
    p0 = pulse_cnt;
    keys_down[2*4+3] = 1'b1;
    repeat (1000) @(negedge clk);
    keys_down = '0;
    repeat (300) @(negedge clk);
    check("letterC_no_pulse", pulse_cnt, p0);
    check("letterC_value", digitos_value, model);
    keys_down[0] = 1'b1;
    keys_down[1] = 1'b1;
    repeat (1000) @(negedge clk);
    keys_down = '0;
    repeat (300) @(negedge clk);
    check("chord_no_pulse", pulse_cnt, p0);
    check("chord_value", digitos_value, model);

    // Disable clears buffer and parks the rows
    enable = 1'b0;
    @(negedge clk);
    check("dis_lin", lin_matrix, 4'hF);
    check("dis_value", digitos_value, SENHA_EMPTY);
    check("dis_valid", digitos_valid, 1'b0);
    model  = SENHA_EMPTY;
    enable = 1'b1;
    @(negedge clk);
    check("reen_lin", lin_matrix, 4'b1110);

    // 21 digits: oldest one falls off the end
    for (int i = 0; i < 20; i++) press_digit(i % 10);
    press_digit(7);
    check("full_digit0", digitos_value.digits[0], 4'h7);
    check("full_digit19", digitos_value.digits[19], 4'h1);
    check("full_value", digitos_value, model);
    check("full_pulses", pulse_cnt, exp_pulses);

    // Inactivity after '9'
    press_key(2, 2, 4'h9, "key9");
    repeat (5400) @(negedge clk);
`ifdef TIMEOUT_CLEAR_EN
    check("timeout_value", digitos_value, SENHA_EMPTY);
`else
    check("hold_digit0", digitos_value.digits[0], 4'h9);
    check("hold_value", digitos_value, model);
`endif
    check("idle_pulses", pulse_cnt, exp_pulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
